// File: rtl/div_share_sched.sv
// div_share_sched: round-robin arbiter sharing one pipelined divider among NREQ requesters,
// with an in-order tag FIFO that routes each divider result back to its issuer.
module div_share_sched #(
  parameter int NREQ  = 4,
  parameter int W     = 16,
  parameter int DEPTH = 32,
  parameter int IDW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_dividend,
  input  logic [NREQ*W-1:0] req_divisor,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_quotient,
  output logic [W-1:0]      resp_remainder,
  output logic              resp_dbz,
  output logic              div_open,
  output logic [W-1:0]      div_dividend,
  output logic [W-1:0]      div_divisor,
  input  logic              div_finish,
  input  logic [W-1:0]      div_quotient,
  input  logic [W-1:0]      div_remainder,
  output logic              busy,
  output logic              err_orphan
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] dvd [NREQ];
  logic [W-1:0] dvs [NREQ];
  logic [IDW:0] tag_mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [IDW-1:0] rr_ptr, gnt_id, cand;
  logic gnt, pop;
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign dvd[i] = req_dividend[i*W +: W];
    assign dvs[i] = req_divisor[i*W +: W];
  end
  // first valid requester after the last winner; nothing is granted while the tag FIFO is full
  always_comb begin
    gnt_id = '0;
    cand = '0;
    gnt = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt && req_valid[cand]) begin
        gnt = 1'b1;
        gnt_id = cand;
      end
    end
    gnt = gnt && (count != CW'(DEPTH));
    req_ready = '0;
    req_ready[gnt_id] = gnt;
  end
  assign pop = div_finish && (count != '0);
  assign busy = count != '0;
  always_ff @(posedge clk)
    if (gnt) tag_mem[wp] <= {gnt_id, dvs[gnt_id] == '0};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_open <= 1'b0;
      div_dividend <= '0;
      div_divisor <= '0;
      resp_valid <= '0;
      resp_quotient <= '0;
      resp_remainder <= '0;
      resp_dbz <= 1'b0;
      err_orphan <= 1'b0;
      rr_ptr <= IDW'(NREQ - 1);
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      div_open <= gnt;
      if (gnt) begin
        div_dividend <= dvd[gnt_id];
        div_divisor <= dvs[gnt_id];
        rr_ptr <= gnt_id;
        wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      end
      resp_valid <= pop ? NREQ'(1) << tag_mem[rp][IDW:1] : '0;
      if (pop) begin
        resp_quotient <= div_quotient;
        resp_remainder <= div_remainder;
        resp_dbz <= tag_mem[rp][0];
        rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      end
      if (div_finish && count == '0) err_orphan <= 1'b1;
      count <= count + CW'(gnt) - CW'(pop);
    end
endmodule

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched: randomized and directed checks of div_share_sched against a
// transaction-level model (arbitration rule, expected-response queue, in-order divider core).
module tb_div_share_sched;
  localparam int NREQ = 4, W = 16, DEPTH = 32, IDW = 2, L = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_ready, resp_valid;
  logic [NREQ*W-1:0] req_dividend, req_divisor;
  logic [W-1:0] resp_quotient, resp_remainder, div_dividend, div_divisor;
  logic [W-1:0] div_quotient = '0, div_remainder = '0;
  logic resp_dbz, div_open, busy, err_orphan;
  logic div_finish = 1'b0;
  logic [W-1:0] a_op [NREQ];
  logic [W-1:0] b_op [NREQ];
  typedef struct {int id; logic [W-1:0] q; logic [W-1:0] r; logic dbz;} exp_t;
  typedef struct {int t; logic [W-1:0] q; logic [W-1:0] r;} core_t;
  exp_t exp_q[$];
  core_t cq[$];
  int gnt_log[$];
  int checks = 0, errors = 0, tcyc = 0, ccyc = 0, n_orph = 0;
  int m_rr = NREQ - 1, m_cnt = 0;
  logic m_orph = 1'b0, m_open = 1'b0, fin_en = 1'b1, fin_force = 1'b0;
  logic [W-1:0] m_dvd = '0, m_dvs = '0;
  logic [NREQ-1:0] last_xfer = '0;

  always #5 clk = ~clk;
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_dividend[g*W +: W] = a_op[g];
    assign req_divisor[g*W +: W] = b_op[g];
  end

  div_share_sched #(.NREQ(NREQ), .W(W), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .resp_valid(resp_valid),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder), .resp_dbz(resp_dbz),
    .div_open(div_open), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_finish(div_finish), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .busy(busy), .err_orphan(err_orphan));

  function automatic logic [W-1:0] quo(logic [W-1:0] a, logic [W-1:0] b);
    return (b == '0) ? '1 : a / b;
  endfunction
  function automatic logic [W-1:0] rem(logic [W-1:0] a, logic [W-1:0] b);
    return (b == '0) ? a : a % b;
  endfunction

  // in-order divider core of latency L; it ignores rst_n so in-flight results outlive a reset
  always @(posedge clk) begin
    ccyc <= ccyc + 1;
    if (div_open) cq.push_back('{ccyc, quo(div_dividend, div_divisor), rem(div_dividend, div_divisor)});
    if (cq.size() > 0 && ((fin_en && ccyc - cq[0].t >= L - 1) || fin_force)) begin
      div_finish <= 1'b1;
      div_quotient <= cq[0].q;
      div_remainder <= cq[0].r;
      void'(cq.pop_front());
    end else div_finish <= 1'b0;
  end

  task automatic tick();
    logic [NREQ-1:0] er;
    int gid;
    exp_t e;
    @(negedge clk);
    er = '0;
    gid = -1;
    if (m_cnt < DEPTH)
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_rr + k) % NREQ;
        if (gid < 0 && req_valid[IDW'(j)]) gid = j;
      end
    if (gid >= 0) er[IDW'(gid)] = 1'b1;
    checks++;
    if (req_ready !== er) begin
      errors++;
      $display("FAIL arbitration cyc %0d: req_ready=%b expected %b", tcyc, req_ready, er);
    end
    checks++;
    if (busy !== (m_cnt != 0)) begin
      errors++;
      $display("FAIL busy cyc %0d: busy=%b expected %b", tcyc, busy, m_cnt != 0);
    end
    checks++;
    if (err_orphan !== m_orph) begin
      errors++;
      $display("FAIL err_orphan cyc %0d: got %b expected %b", tcyc, err_orphan, m_orph);
    end
    checks++;
    if (div_open !== m_open || (m_open && (div_dividend !== m_dvd || div_divisor !== m_dvs))) begin
      errors++;
      $display("FAIL issue cyc %0d: open=%b %0d/%0d expected open=%b %0d/%0d",
               tcyc, div_open, div_dividend, div_divisor, m_open, m_dvd, m_dvs);
    end
    if (resp_valid !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL response cyc %0d: resp_valid=%b expected none", tcyc, resp_valid);
      end else begin
        e = exp_q.pop_front();
        if (resp_valid !== (NREQ'(1) << e.id) || resp_dbz !== e.dbz ||
            (!e.dbz && (resp_quotient !== e.q || resp_remainder !== e.r))) begin
          errors++;
          $display("FAIL response cyc %0d: valid=%b q=%0d r=%0d dbz=%b expected valid=%b q=%0d r=%0d dbz=%b",
                   tcyc, resp_valid, resp_quotient, resp_remainder, resp_dbz,
                   NREQ'(1) << e.id, e.q, e.r, e.dbz);
        end
      end
    end
    if (div_finish) begin
      if (m_cnt > 0) m_cnt--;
      else begin
        m_orph = 1'b1;
        n_orph++;
      end
    end
    last_xfer = er & req_valid;
    m_open = 1'b0;
    if (gid >= 0) begin
      exp_q.push_back('{gid, quo(a_op[gid], b_op[gid]), rem(a_op[gid], b_op[gid]), b_op[gid] == '0});
      m_rr = gid;
      m_cnt++;
      gnt_log.push_back(gid);
      m_open = 1'b1;
      m_dvd = a_op[gid];
      m_dvs = b_op[gid];
    end
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic drain(int max);
    int n = 0;
    while ((m_cnt != 0 || exp_q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (m_cnt != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding after %0d cycles, expected 0", exp_q.size(), max);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({div_open, div_dividend, div_divisor, resp_valid, resp_quotient, resp_remainder,
         resp_dbz, err_orphan, busy, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset: open=%b dvd=%0d dvs=%0d rv=%b q=%0d r=%0d dbz=%b orph=%b busy=%b ready=%b expected all 0",
               div_open, div_dividend, div_divisor, resp_valid, resp_quotient, resp_remainder,
               resp_dbz, err_orphan, busy, req_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    gnt_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = 40;
      b_op[i] = W'(i + 1);
    end
    req_valid = '1;
    for (int n = 0; n < 10 && req_valid != '0; n++) begin
      tick();
      req_valid &= ~last_xfer;
    end
    for (int k = 0; k < NREQ; k++) begin
      checks++;
      if (gnt_log.size() <= k || gnt_log[k] != k) begin
        errors++;
        $display("FAIL contention grant %0d: got %0d expected %0d", k,
                 (gnt_log.size() > k) ? gnt_log[k] : -1, k);
      end
    end
    drain(30);
  endtask

  task automatic test_fairness();
    gnt_log.delete();
    a_op[1] = W'($urandom);
    b_op[1] = W'($urandom_range(1, 500));
    a_op[3] = W'($urandom);
    b_op[3] = W'($urandom_range(1, 500));
    req_valid = 4'b1010;
    for (int n = 0; n < 40 && gnt_log.size() < 8; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++)
        if (last_xfer[i]) begin
          a_op[i] = W'($urandom);
          b_op[i] = W'($urandom_range(1, 500));
        end
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (gnt_log.size() <= k || gnt_log[k] != ((k % 2 == 0) ? 1 : 3)) begin
        errors++;
        $display("FAIL fairness grant %0d: got %0d expected %0d", k,
                 (gnt_log.size() > k) ? gnt_log[k] : -1, (k % 2 == 0) ? 1 : 3);
      end
    end
    drain(40);
  endtask

  task automatic test_single();
    int t0;
    a_op[0] = 100;
    b_op[0] = 7;
    req_valid = 4'b0001;
    t0 = tcyc;
    tick();
    req_valid = '0;
    checks++;
    if (div_open !== 1'b1 || div_dividend !== 16'd100 || div_divisor !== 16'd7) begin
      errors++;
      $display("FAIL single issue: open=%b %0d/%0d expected open=1 100/7", div_open, div_dividend, div_divisor);
    end
    for (int n = 0; n < 20 && resp_valid === '0; n++) tick();
    checks++;
    if (tcyc - t0 != L + 2) begin
      errors++;
      $display("FAIL single latency: %0d cycles expected %0d", tcyc - t0, L + 2);
    end
    checks++;
    if (resp_valid !== 4'b0001 || resp_quotient !== 16'd14 || resp_remainder !== 16'd2 || resp_dbz !== 1'b0) begin
      errors++;
      $display("FAIL single result: valid=%b q=%0d r=%0d dbz=%b expected 0001 q=14 r=2 dbz=0",
               resp_valid, resp_quotient, resp_remainder, resp_dbz);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single busy after pop: got %b expected 0", busy);
    end
    drain(10);
  endtask

  task automatic test_dbz();
    a_op[3] = 55;
    b_op[3] = 0;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    for (int n = 0; n < 20 && resp_valid === '0; n++) tick();
    checks++;
    if (resp_valid !== 4'b1000 || resp_dbz !== 1'b1) begin
      errors++;
      $display("FAIL dbz flag: valid=%b dbz=%b expected 1000 dbz=1", resp_valid, resp_dbz);
    end
    a_op[3] = 9;
    b_op[3] = 3;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    for (int n = 0; n < 20 && resp_valid === '0; n++) tick();
    checks++;
    if (resp_valid !== 4'b1000 || resp_quotient !== 16'd3 || resp_remainder !== 16'd0 || resp_dbz !== 1'b0) begin
      errors++;
      $display("FAIL dbz follow-up: valid=%b q=%0d r=%0d dbz=%b expected 1000 q=3 r=0 dbz=0",
               resp_valid, resp_quotient, resp_remainder, resp_dbz);
    end
    drain(20);
  endtask

  task automatic test_backpressure();
    int nx = 0;
    fin_en = 1'b0;
    a_op[2] = W'($urandom);
    b_op[2] = W'($urandom_range(1, 900));
    req_valid = 4'b0100;
    for (int n = 0; n < 40; n++) begin
      tick();
      nx += $countones(last_xfer);
      if (last_xfer[2]) begin
        a_op[2] = W'($urandom);
        b_op[2] = W'($urandom_range(1, 900));
      end
    end
    checks++;
    if (nx != DEPTH || req_ready !== '0) begin
      errors++;
      $display("FAIL backpressure fill: %0d transfers ready=%b expected %0d ready=0000", nx, req_ready, DEPTH);
    end
    nx = 0;
    fin_force = 1'b1;
    tick();
    fin_force = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      nx += $countones(last_xfer);
    end
    checks++;
    if (nx != 1) begin
      errors++;
      $display("FAIL backpressure single pop: %0d transfers expected 1", nx);
    end
    req_valid = '0;
    fin_en = 1'b1;
    drain(100);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_xfer[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          a_op[i] = W'($urandom);
          b_op[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 300));
        end else if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end
      fin_en = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    fin_en = 1'b1;
    drain(100);
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      a_op[i] = W'($urandom);
      b_op[i] = W'($urandom_range(1, 50));
    end
    req_valid = 4'b0111;
    for (int n = 0; n < 10 && req_valid != '0; n++) begin
      tick();
      req_valid &= ~last_xfer;
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({div_open, div_dividend, div_divisor, resp_valid, resp_quotient, resp_remainder,
         resp_dbz, err_orphan, busy} !== '0) begin
      errors++;
      $display("FAIL midop reset: open=%b dvd=%0d dvs=%0d rv=%b q=%0d r=%0d dbz=%b orph=%b busy=%b expected all 0",
               div_open, div_dividend, div_divisor, resp_valid, resp_quotient, resp_remainder,
               resp_dbz, err_orphan, busy);
    end
    m_cnt = 0;
    m_rr = NREQ - 1;
    m_open = 1'b0;
    m_orph = 1'b0;
    n_orph = 0;
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    repeat (10) tick();
    checks++;
    if (n_orph != 3 || err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphans: %0d late finishes err_orphan=%b expected 3 and 1", n_orph, err_orphan);
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = '0;
      b_op[i] = 16'd1;
    end
    test_reset();
    test_contention();
    test_fairness();
    test_single();
    test_dbz();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
Round-robin scheduler that shares one pipelined 16-bit divider core among NREQ requesters. It accepts valid/ready requests and issues at most one operation per cycle to the divider's open/dividend/divisor inputs. It tags each issue in an in-order tag FIFO and routes each divider result (finish/quotient/remainder) back to the requester that issued it. It sits between the mGPU compute lanes and the single divider instance.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, operand/result width; matches divider core
DEPTH, 32, tag FIFO entries; must be >= divider latency + 2 for full throughput
IDW, 2, requester-id width, clog2(NREQ)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant/accept (combinational)
req_dividend  in  NREQ*W  packed dividends, requester i at [i*W +: W]
req_divisor  in  NREQ*W  packed divisors, same packing
resp_valid  out  NREQ  one-cycle result strobe, one-hot or zero
resp_quotient  out  W  quotient for the strobed requester
resp_remainder  out  W  remainder for the strobed requester
resp_dbz  out  1  qualifies resp_valid: the operation had divisor==0
div_open  out  1  to divider core: operand valid
div_dividend  out  W  to divider core
div_divisor  out  W  to divider core
div_finish  in  1  from divider core: result valid (no backpressure)
div_quotient  in  W  from divider core
div_remainder  in  W  from divider core
busy  out  1  tag FIFO non-empty
err_orphan  out  1  sticky: div_finish seen while tag FIFO empty

Behaviour:
- Reset (async, rst_n=0): div_open=0, div_dividend=0, div_divisor=0, resp_valid=0, resp_quotient=0, resp_remainder=0, resp_dbz=0, err_orphan=0. Tag FIFO emptied (count=0, pointers=0). RR pointer=NREQ-1, so requester 0 has first priority.
- Arbitration (combinational): with count<DEPTH, grant the first requester with req_valid=1, searching from rr_ptr+1 modulo NREQ. req_ready is one-hot on the granted index, otherwise all zero. At count==DEPTH, req_ready=0.
- Handshake: transfer when req_valid[i]&req_ready[i]. Requester holds valid and operands until ready. Deasserting valid before ready is allowed and drops nothing.
- On transfer in cycle N:
  - rr_ptr<=i.
  - Push {i, divisor==0} into the tag FIFO.
  - Cycle N+1: div_open=1, div_dividend/div_divisor = that requester's operands.
- No transfer: div_open<=0, operands hold their last value, rr_ptr unchanged.
- Throughput: one issue per cycle sustained.
- Return: in cycle M with div_finish=1 and FIFO non-empty:
  - Pop the head tag.
  - Cycle M+1: resp_valid[tag.id]=1, resp_quotient/resp_remainder registered from the divider outputs, resp_dbz=tag.dbz.
  - Otherwise resp_valid=0; data holds its last value.
- Ordering: the divider returns in issue order, so the FIFO head always matches the result.
- Simultaneous push and pop: count unchanged, both take effect. Push when full cannot happen because ready is gated.
- div_finish with the FIFO empty: result dropped, no resp_valid, err_orphan<=1 (cleared only by reset).
- Reset mid-operation: in-flight divider results arriving after reset are orphans. They are dropped and set err_orphan. Software/bench must treat err_orphan after a mid-op reset as expected.
- Divide by zero: issued normally. The quotient/remainder values come from the core, unspecified. resp_dbz=1 flags them.
- busy = (count != 0).
- End-to-end latency = 1 (issue register) + L (core latency) + 1 (response register) cycles from transfer to resp_valid.

Test Plan:
- Single op: requester 0 sends 100/7 in cycle 0 -> div_open=1 cycle 1, resp_valid=4'b0001 at cycle L+2, quotient 14, remainder 2, resp_dbz=0, busy falls the cycle after pop.
- Contention: all four valid in cycle 0 with operands 40/i+1 -> grants in order 0,1,2,3 on consecutive cycles. Responses in the same order with quotients 40,20,13,10 and remainders 0,0,1,0.
- Fairness: requesters 1 and 3 held valid for 8 transfers -> grants alternate 1,3,1,3. No requester is granted twice while the other waits.
- Backpressure: bench divider never asserts finish, requester 2 streams -> exactly DEPTH(32) transfers, then req_ready=0. One finish pulse -> exactly one more transfer is accepted.
- Divide by zero: requester 3 sends 55/0 -> resp_valid=4'b1000 with resp_dbz=1. A following 9/3 returns quotient 3, resp_dbz=0.
- Reset mid-op: 3 ops in flight, rst_n pulsed low -> all outputs 0 immediately. The 3 late finishes produce no resp_valid and err_orphan=1.
